// File: rtl/kronos_csr_if.sv
// CSR access channel between the Write Back stage (master) and the CSR file (slave).
// Handshake: master raises csr_rd_req with addr/op/wr_data stable and holds it until csr_gnt; slave pulses
// csr_gnt for exactly one cycle with csr_rd_data valid; master then drops csr_rd_req and may assert
// csr_wr_req for one cycle to commit (no grant for the write). csr_wr_req without a read commits directly.
interface kronos_csr_if;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_rd_data;
  logic [31:0] csr_wr_data;
  logic        csr_rd_req;
  logic        csr_wr_req;
  logic        csr_gnt;

  modport master (
    output csr_addr, csr_op, csr_wr_data, csr_rd_req, csr_wr_req,
    input  csr_rd_data, csr_gnt
  );

  modport slave (
    input  csr_addr, csr_op, csr_wr_data, csr_rd_req, csr_wr_req,
    output csr_rd_data, csr_gnt
  );
endinterface

// File: rtl/kronos_csr.sv
// Machine-mode CSR file: read-grant-then-commit access FSM, trap CSRs and 64-bit cycle/instret counters.
module kronos_csr #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rstz,
  kronos_csr_if.slave   csr,
  input  logic          instret,
  output logic [31:0]   mtvec,
  output logic [31:0]   mepc,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT_WR = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] mtvec_q, mepc_q, mscratch_q, mcause_q;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [31:0] rd_val, rmw_old, wr_val;
  logic        commit, wr_en;
  logic        we_mtvec, we_mscratch, we_mepc, we_mcause;
  logic        we_mcycle, we_mcycleh, we_minstret, we_minstreth;
  logic [63:0] cyc_inc, ins_inc;

  always_comb begin
    rd_val = 32'd0;
    case (csr.csr_addr)
      12'h301: rd_val = 32'h4000_0100;
      12'hF14: rd_val = HART_ID;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'hB00: rd_val = mcycle_q[31:0];
      12'hB80: rd_val = mcycle_q[63:32];
      12'hB02: rd_val = minstret_q[31:0];
      12'hB82: rd_val = minstret_q[63:32];
      default: rd_val = 32'd0;
    endcase
  end

  // A write with no preceding read uses the live register value as the RMW base.
  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    commit    = 1'b0;
    rmw_old   = rd_val;
    case (state_q)
      IDLE: begin
        commit = csr.csr_wr_req;
        if (csr.csr_rd_req) begin
          state_d   = GRANT;
          rd_data_d = rd_val;
        end
      end
      GRANT:   state_d = WAIT_WR;
      WAIT_WR: begin
        rmw_old = rd_data_q;
        if (csr.csr_wr_req) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_val = csr.csr_wr_data;
    case (csr.csr_op)
      2'b10:   wr_val = rmw_old | csr.csr_wr_data;
      2'b11:   wr_val = rmw_old & ~csr.csr_wr_data;
      default: wr_val = csr.csr_wr_data;
    endcase
  end

  assign wr_en        = commit && (csr.csr_op != 2'b00);
  assign we_mtvec     = wr_en && (csr.csr_addr == 12'h305);
  assign we_mscratch  = wr_en && (csr.csr_addr == 12'h340);
  assign we_mepc      = wr_en && (csr.csr_addr == 12'h341);
  assign we_mcause    = wr_en && (csr.csr_addr == 12'h342);
  assign we_mcycle    = wr_en && (csr.csr_addr == 12'hB00);
  assign we_mcycleh   = wr_en && (csr.csr_addr == 12'hB80);
  assign we_minstret  = wr_en && (csr.csr_addr == 12'hB02);
  assign we_minstreth = wr_en && (csr.csr_addr == 12'hB82);

  // Writing a low half freezes the high half for that cycle (its carry is dropped).
  always_comb begin
    cyc_inc  = mcycle_q + 64'd1;
    ins_inc  = minstret_q + {63'd0, instret};
    mcycle_d = cyc_inc;
    if (we_mcycle)  mcycle_d = {mcycle_q[63:32], wr_val};
    if (we_mcycleh) mcycle_d = {wr_val, cyc_inc[31:0]};
    minstret_d = ins_inc;
    if (we_minstret)  minstret_d = {minstret_q[63:32], wr_val};
    if (we_minstreth) minstret_d = {wr_val, ins_inc[31:0]};
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q    <= IDLE;
      rd_data_q  <= 32'd0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mepc_q     <= 32'd0;
      mscratch_q <= 32'd0;
      mcause_q   <= 32'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (we_mtvec)    mtvec_q    <= {wr_val[31:2], 2'b00};
      if (we_mepc)     mepc_q     <= {wr_val[31:2], 2'b00};
      if (we_mscratch) mscratch_q <= wr_val;
      if (we_mcause)   mcause_q   <= wr_val;
    end
  end

  assign csr.csr_rd_data = rd_data_q;
  assign csr.csr_gnt     = (state_q == GRANT);
  assign mtvec           = mtvec_q;
  assign mepc            = mepc_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_kronos_csr.sv
// Directed bench for kronos_csr: read data is checked against a queue of expected old values.
module tb_kronos_csr;
  localparam logic [31:0] HART = 32'd3;
  localparam logic [31:0] MTV_RST = 32'h0000_1003;

  logic        clk = 1'b0;
  logic        rstz;
  logic        instret;
  logic [31:0] mtvec, mepc;
  logic [1:0]  dbg_state;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs;

  kronos_csr_if bus ();

  kronos_csr #(.HART_ID(HART), .MTVEC_RESET(MTV_RST)) dut (
    .clk(clk), .rstz(rstz), .csr(bus), .instret(instret),
    .mtvec(mtvec), .mepc(mepc), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Full read/grant/commit transaction; exp is the old value the grant must return.
  task automatic txn(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                     input logic [31:0] exp, input bit chk, output logic [31:0] o);
    bit got;
    logic [31:0] e;
    @(posedge clk); #1;
    bus.csr_addr = a; bus.csr_op = op; bus.csr_wr_data = wd; bus.csr_rd_req = 1'b1;
    if (chk) exp_q.push_back(exp);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.csr_gnt) got = 1'b1;
    end
    o = bus.csr_rd_data;
    check($sformatf("gnt_%03h", a), {31'd0, got}, 32'd1);
    if (chk && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got) check($sformatf("rd_%03h", a), o, e);
    end
    bus.csr_rd_req = 1'b0;
    @(posedge clk); #1;
    check("gnt_single", {31'd0, bus.csr_gnt}, 32'd0);
    bus.csr_wr_req = 1'b1;
    @(posedge clk); #1;
    bus.csr_wr_req = 1'b0;
    bus.csr_op = 2'b00;
  endtask

  task automatic wr_only(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    bus.csr_addr = a; bus.csr_op = op; bus.csr_wr_data = wd; bus.csr_wr_req = 1'b1;
    @(posedge clk); #1;
    bus.csr_wr_req = 1'b0;
    bus.csr_op = 2'b00;
  endtask

  initial begin
    rstz = 1'b0; instret = 1'b0;
    bus.csr_addr = 12'd0; bus.csr_op = 2'b00; bus.csr_wr_data = 32'd0;
    bus.csr_rd_req = 1'b0; bus.csr_wr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {31'd0, bus.csr_gnt}, 32'd0);
    check("rst_rd_data", bus.csr_rd_data, 32'd0);
    check("rst_mtvec", mtvec, 32'h0000_1000);
    check("rst_mepc", mepc, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rstz = 1'b1;

    for (int i = 0; i < 3; i++) begin
      instret = 1'b1; @(posedge clk); #1;
    end
    instret = 1'b0;
    txn(12'hB02, 2'b00, 32'd0, 32'd3, 1'b1, obs);
    txn(12'hB82, 2'b00, 32'd0, 32'd0, 1'b1, obs);

    txn(12'h340, 2'b01, 32'hDEAD_BEEF, 32'd0, 1'b1, obs);
    txn(12'h340, 2'b00, 32'd0, 32'hDEAD_BEEF, 1'b1, obs);
    txn(12'h340, 2'b01, 32'hF0F0_0000, 32'hDEAD_BEEF, 1'b1, obs);
    txn(12'h340, 2'b10, 32'h0000_00FF, 32'hF0F0_0000, 1'b1, obs);
    txn(12'h340, 2'b11, 32'hF000_0000, 32'hF0F0_00FF, 1'b1, obs);
    txn(12'h340, 2'b00, 32'd0, 32'h00F0_00FF, 1'b1, obs);

    txn(12'h305, 2'b01, 32'h8000_0003, 32'h0000_1000, 1'b1, obs);
    check("mtvec_port", mtvec, 32'h8000_0000);
    txn(12'h305, 2'b00, 32'd0, 32'h8000_0000, 1'b1, obs);

    txn(12'h301, 2'b01, 32'd0, 32'h4000_0100, 1'b1, obs);
    txn(12'h301, 2'b00, 32'd0, 32'h4000_0100, 1'b1, obs);
    txn(12'hF14, 2'b01, 32'hFFFF_FFFF, HART, 1'b1, obs);
    txn(12'h7C0, 2'b01, 32'h1234_5678, 32'd0, 1'b1, obs);
    txn(12'h7C0, 2'b00, 32'd0, 32'd0, 1'b1, obs);

    txn(12'h341, 2'b01, 32'h1234_5677, 32'd0, 1'b1, obs);
    check("mepc_port", mepc, 32'h1234_5674);
    txn(12'h342, 2'b01, 32'h8000_000B, 32'd0, 1'b1, obs);
    txn(12'h342, 2'b00, 32'd0, 32'h8000_000B, 1'b1, obs);

    // Back-to-back direct commits: low half then high half, then let the low half roll over.
    @(posedge clk); #1;
    wr_only(12'hB00, 2'b01, 32'hFFFF_FFFE);
    wr_only(12'hB80, 2'b01, 32'd0);
    txn(12'hB80, 2'b00, 32'd0, 32'd1, 1'b1, obs);
    txn(12'hB00, 2'b00, 32'd0, 32'd0, 1'b0, obs);
    check("mcycle_lo_small", {31'd0, (obs < 32'd16)}, 32'd1);

    @(posedge clk); #1;
    instret = 1'b1;
    wr_only(12'hB02, 2'b01, 32'd5);
    instret = 1'b0;
    txn(12'hB02, 2'b00, 32'd0, 32'd5, 1'b1, obs);
    txn(12'hB82, 2'b00, 32'd0, 32'd0, 1'b1, obs);

    // Abort a transaction with reset while it waits for its write strobe.
    @(posedge clk); #1;
    bus.csr_addr = 12'h340; bus.csr_op = 2'b01; bus.csr_wr_data = 32'h1234_5678;
    bus.csr_rd_req = 1'b1;
    exp_q.push_back(32'h00F0_00FF);
    @(posedge clk); #1;
    check("abort_gnt", {31'd0, bus.csr_gnt}, 32'd1);
    check("abort_rd", bus.csr_rd_data, exp_q.pop_front());
    bus.csr_rd_req = 1'b0;
    @(posedge clk); #1;
    check("abort_wait_state", {30'd0, dbg_state}, 32'd2);
    rstz = 1'b0;
    #1;
    check("abort_rst_gnt", {31'd0, bus.csr_gnt}, 32'd0);
    check("abort_rst_state", {30'd0, dbg_state}, 32'd0);
    check("abort_rst_mtvec", mtvec, 32'h0000_1000);
    check("abort_rst_rd", bus.csr_rd_data, 32'd0);
    @(posedge clk); #1;
    rstz = 1'b1;
    bus.csr_op = 2'b00;
    txn(12'h340, 2'b00, 32'd0, 32'd0, 1'b1, obs);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
